// File: rtl/ifetch_req_tracker.sv
// ifetch_req_tracker: in-order tracker between fetch requests and I-cache responses.
// Each issued fetch address is queued with a live bit. Every response pops the oldest
// entry and is checked against it. A flush kills outstanding entries so that their late
// responses are absorbed and dropped. Sticky error flags and counters are kept for reporting.
// Optional feature macro: IFETCH_TRACKER_PERF_EN (busy_cycles / max_occupancy counters).
module ifetch_req_tracker #(
  parameter int unsigned ADDRESS_BITS = 12,
  parameter int unsigned DEPTH        = 2,
  parameter int unsigned CNT_BITS     = 32
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      flush,
  input  logic                      req_valid,
  input  logic [ADDRESS_BITS-1:0]   req_addr,
  output logic                      req_ready,
  input  logic                      rsp_valid,
  input  logic [ADDRESS_BITS-1:0]   rsp_addr,
  output logic                      rsp_ok,
  output logic                      rsp_drop,
  output logic [$clog2(DEPTH):0]    outstanding,
  output logic                      err_mismatch,
  output logic                      err_overflow,
  output logic                      err_underflow,
  output logic [CNT_BITS-1:0]       req_cnt,
  output logic [CNT_BITS-1:0]       mismatch_cnt,
  output logic [CNT_BITS-1:0]       busy_cycles,
  output logic [$clog2(DEPTH):0]    max_occupancy
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned OCC_W = $clog2(DEPTH) + 1;

  logic [ADDRESS_BITS-1:0] r_addr [DEPTH];
  logic [DEPTH-1:0]        r_live;
  logic [PTR_W-1:0]        r_rd_ptr;
  logic [PTR_W-1:0]        r_wr_ptr;
  logic [OCC_W-1:0]        r_count;
  logic                    r_rsp_ok;
  logic                    r_rsp_drop;
  logic                    r_err_mismatch;
  logic                    r_err_overflow;
  logic                    r_err_underflow;
  logic [CNT_BITS-1:0]     r_req_cnt;
  logic [CNT_BITS-1:0]     r_mismatch_cnt;

  logic                    w_full;
  logic                    w_empty;
  logic                    w_push;
  logic                    w_pop;
  logic                    w_head_live;
  logic                    w_head_match;
  logic [OCC_W-1:0]        w_count_nxt;
  logic [DEPTH-1:0]        w_live_nxt;

  // Handshake decode, occupancy and live-bit next state
  always_comb begin
    w_full       = (r_count == OCC_W'(DEPTH));
    w_empty      = (r_count == '0);
    w_push       = req_valid & ~w_full;
    w_pop        = rsp_valid & ~w_empty;
    w_head_live  = r_live[r_rd_ptr];
    w_head_match = (r_addr[r_rd_ptr] == rsp_addr);

    w_count_nxt = r_count;
    if (w_push && !w_pop) begin
      w_count_nxt = r_count + OCC_W'(1);
    end else if (w_pop && !w_push) begin
      w_count_nxt = r_count - OCC_W'(1);
    end

    // Flush kills every entry held before the edge; a same-cycle push is the redirect target.
    w_live_nxt = r_live;
    if (flush) begin
      w_live_nxt = '0;
    end else if (w_pop) begin
      w_live_nxt[r_rd_ptr] = 1'b0;
    end
    if (w_push) begin
      w_live_nxt[r_wr_ptr] = 1'b1;
    end
  end

  // Address storage; contents are qualified by occupancy so no reset is needed
  always_ff @(posedge clock) begin
    if (w_push) begin
      r_addr[r_wr_ptr] <= req_addr;
    end
  end

  // Pointers, occupancy, response pulses, sticky flags and event counters
  always_ff @(posedge clock) begin
    if (reset) begin
      r_live          <= '0;
      r_rd_ptr        <= '0;
      r_wr_ptr        <= '0;
      r_count         <= '0;
      r_rsp_ok        <= 1'b0;
      r_rsp_drop      <= 1'b0;
      r_err_mismatch  <= 1'b0;
      r_err_overflow  <= 1'b0;
      r_err_underflow <= 1'b0;
      r_req_cnt       <= '0;
      r_mismatch_cnt  <= '0;
    end else begin
      r_live     <= w_live_nxt;
      r_count    <= w_count_nxt;
      r_rsp_ok   <= w_pop & w_head_live & w_head_match;
      r_rsp_drop <= w_pop & ~w_head_live;
      if (w_push) begin
        r_wr_ptr  <= r_wr_ptr + PTR_W'(1);
        r_req_cnt <= r_req_cnt + CNT_BITS'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      if (w_pop && w_head_live && !w_head_match) begin
        r_err_mismatch <= 1'b1;
        r_mismatch_cnt <= r_mismatch_cnt + CNT_BITS'(1);
      end
      if (req_valid && w_full) begin
        r_err_overflow <= 1'b1;
      end
      if (rsp_valid && w_empty) begin
        r_err_underflow <= 1'b1;
      end
    end
  end

`ifdef IFETCH_TRACKER_PERF_EN
  logic [CNT_BITS-1:0] r_busy_cycles;
  logic [OCC_W-1:0]    r_max_occupancy;

  // Occupancy statistics: busy cycles sampled before the edge, peak after it
  always_ff @(posedge clock) begin
    if (reset) begin
      r_busy_cycles   <= '0;
      r_max_occupancy <= '0;
    end else begin
      if (!w_empty) begin
        r_busy_cycles <= r_busy_cycles + CNT_BITS'(1);
      end
      if (w_count_nxt > r_max_occupancy) begin
        r_max_occupancy <= w_count_nxt;
      end
    end
  end

  assign busy_cycles   = r_busy_cycles;
  assign max_occupancy = r_max_occupancy;
`else
  assign busy_cycles   = '0;
  assign max_occupancy = '0;
`endif

  assign req_ready     = ~w_full;
  assign outstanding   = r_count;
  assign rsp_ok        = r_rsp_ok;
  assign rsp_drop      = r_rsp_drop;
  assign err_mismatch  = r_err_mismatch;
  assign err_overflow  = r_err_overflow;
  assign err_underflow = r_err_underflow;
  assign req_cnt       = r_req_cnt;
  assign mismatch_cnt  = r_mismatch_cnt;

endmodule
